// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: control codes, FSM encoding
// and default datapath sizes.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_legal_code(input logic [3:0] code);
        logic legal;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_SLT, ALU_SLTU, ALU_SLL: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU operations with signed-overflow and
// illegal-code / inconsistent-SLL-flag detection.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       alu_ctr,
    input  logic             sll_flag,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic             sltu_bit;

    assign sum      = a + b;
    // Sign-extended subtract: bit WIDTH is the true sign of a-b, immune to overflow.
    assign diff_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign diff     = diff_ext[WIDTH-1:0];
    assign slt_bit  = diff_ext[WIDTH];
    assign sltu_bit = (a < b);

    assign illegal = !is_legal_code(alu_ctr) || (sll_flag != alu_ctr[3]);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (!illegal) begin
            case (alu_ctr)
                ALU_AND:  result = a & b;
                ALU_OR:   result = a | b;
                ALU_ADD: begin
                    result   = sum;
                    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                ALU_SUB: begin
                    result   = diff;
                    overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
                ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_bit};
                default:  result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops through alu_comb_core, SLL through an
// iterative 1-bit-per-cycle shifter, valid/ready on both sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctr,
    input  logic             sll_flag,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    alu_state_e       state_reg, state_next;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             illegal_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [SHW-1:0]   count_reg;

    logic [WIDTH-1:0] core_result;
    logic             core_overflow;
    logic             core_illegal;
    logic             accept;
    logic             is_sll_op;
    logic             last_shift;
    logic [WIDTH-1:0] shift_next;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .alu_ctr  (alu_ctr),
        .sll_flag (sll_flag),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    assign accept     = in_valid && in_ready;
    assign is_sll_op  = (alu_ctr == ALU_SLL) && !core_illegal;
    assign last_shift = (count_reg == SHW'(1));
    assign shift_next = shift_reg << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (is_sll_op && (shamt != '0)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
    end

    // Datapath: everything is captured at accept; operand inputs are not looked at afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            shift_reg    <= '0;
            count_reg    <= '0;
        end else if (accept) begin
            overflow_reg <= core_overflow;
            illegal_reg  <= core_illegal;
            if (is_sll_op) begin
                if (shamt == '0) begin
                    result_reg <= b;
                    zero_reg   <= (b == '0);
                end else begin
                    shift_reg <= b;
                    count_reg <= shamt;
                end
            end else begin
                result_reg <= core_result;
                zero_reg   <= (core_result == '0);
            end
        end else if (state_reg == ST_SHIFT) begin
            shift_reg <= shift_next;
            count_reg <= count_reg - SHW'(1);
            if (last_shift) begin
                result_reg <= shift_next;
                zero_reg   <= (shift_next == '0);
            end
        end
    end

    assign result   = result_reg;
    assign zero     = zero_reg;
    assign overflow = overflow_reg;
    assign illegal  = illegal_reg;

endmodule
